// File: rtl/apu_reg_loader.sv
// apu_reg_loader: turns 4-byte serial packets (SYNC, ADDR, DATA, CHK) into
// single APU register writes over a valid/ready handshake. Also drives the
// link LED and a saturating debug error counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | hunting for SYNC; other bytes ignored without error
// S_ADDR  | SYNC seen, waiting for the register index byte
// S_DATA  | index latched, waiting for the data byte
// S_CHK   | data latched, waiting for the checksum byte
// S_WRITE | write request presented, holding until reg_ready
module apu_reg_loader #(
    parameter int unsigned CLKRATE   = 12_000_000,
    parameter int unsigned BAUDRATE  = 9600,
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter logic [4:0]  MAX_ADDR  = 5'h17,
    parameter int unsigned TIMEOUT   = 40 * CLKRATE / BAUDRATE,
    parameter int unsigned LINK_HOLD = CLKRATE / 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       reg_ready,
    output logic       reg_valid,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       link,
    output logic [7:0] err_cnt
);

    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int LINK_W = $clog2(LINK_HOLD + 1);

    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT);
    localparam logic [LINK_W-1:0] LINK_LOAD = LINK_W'(LINK_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    state_t            state_q;
    logic [7:0]        addr_byte_q;
    logic [7:0]        data_byte_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              reg_valid_q;
    logic [4:0]        reg_addr_q;
    logic [7:0]        reg_data_q;
    logic [7:0]        err_cnt_q;
    logic [7:0]        err_cnt_d;
    logic [LINK_W-1:0] link_cnt_q;
    logic [LINK_W-1:0] link_cnt_d;

    logic in_packet;
    logic tmr_expired;
    logic addr_legal;
    logic chk_ok;
    logic handshake;
    logic err_event;

    // Packet qualification and event decode shared by the FSM and counters.
    always_comb begin
        in_packet   = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
        // The timer sits at zero on the last legal cycle; a byte on that
        // cycle still counts, only silence expires the packet.
        tmr_expired = in_packet && !rx_valid && (tmr_q == '0);
        addr_legal  = (addr_byte_q[7:5] == 3'b000) && (addr_byte_q[4:0] <= MAX_ADDR);
        chk_ok      = (rx_data == (addr_byte_q + data_byte_q));
        handshake   = (state_q == S_WRITE) && reg_valid_q && reg_ready;
        err_event   = 1'b0;
        case (state_q)
            S_CHK:   err_event = rx_valid ? !(chk_ok && addr_legal) : tmr_expired;
            S_ADDR,
            S_DATA:  err_event = tmr_expired;
            S_WRITE: err_event = rx_valid;
            default: err_event = 1'b0;
        endcase
    end

    // Saturating error count: stops at 255 rather than wrapping to zero.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Link hold timer: reloads on every completed write, then drains to zero.
    always_comb begin
        link_cnt_d = link_cnt_q;
        if (handshake) begin
            link_cnt_d = LINK_LOAD;
        end else if (link_cnt_q != '0) begin
            link_cnt_d = link_cnt_q - LINK_W'(1);
        end
    end

    // Packet FSM with registered write-request outputs and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_byte_q <= 8'h00;
            data_byte_q <= 8'h00;
            tmr_q       <= '0;
            reg_valid_q <= 1'b0;
            reg_addr_q  <= 5'h00;
            reg_data_q  <= 8'h00;
            err_cnt_q   <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                S_IDLE: begin
                    tmr_q <= '0;
                    if (rx_valid && (rx_data == SYNC)) begin
                        state_q <= S_ADDR;
                        tmr_q   <= TMR_LOAD;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr_byte_q <= rx_data;
                        tmr_q       <= TMR_LOAD;
                        state_q     <= S_DATA;
                    end else if (tmr_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        data_byte_q <= rx_data;
                        tmr_q       <= TMR_LOAD;
                        state_q     <= S_CHK;
                    end else if (tmr_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_CHK: begin
                    if (rx_valid) begin
                        tmr_q <= '0;
                        if (chk_ok && addr_legal) begin
                            state_q     <= S_WRITE;
                            reg_valid_q <= 1'b1;
                            reg_addr_q  <= addr_byte_q[4:0];
                            reg_data_q  <= data_byte_q;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (tmr_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_WRITE: begin
                    // Bytes arriving here are dropped (counted via err_event);
                    // a SYNC does not start a new packet.
                    tmr_q <= '0;
                    if (handshake) begin
                        reg_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    reg_valid_q <= 1'b0;
                    tmr_q       <= '0;
                end
            endcase
        end
    end

    // Link LED hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_cnt_q <= '0;
        end else begin
            link_cnt_q <= link_cnt_d;
        end
    end

    assign reg_valid = reg_valid_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign err_cnt   = err_cnt_q;
    assign link      = (link_cnt_q != '0);

endmodule
